// File: rtl/oled_i2c_slave.sv
// I2C target front end for the OLED controller: oversampled SCL/SDA, address match,
// SSD1306 control-byte decode, valid/ready byte stream. Option: OLED_I2C_SLAVE_STRETCH_EN.
module oled_i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oen,
  output logic       scl_out,
  output logic       scl_oen,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  input  logic       out_ready,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_CTRL     = 3'd3,
    ST_CTRL_ACK = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam logic [2:0] FLT_LAST = 3'(FILTER_LEN - 1);

  logic [1:0] pin_s, filt_s, prev_s;
  assign pin_s = {sda_in, scl_in};

  for (genvar i = 0; i < 2; i++) begin : g_in
    logic       sync1_q, sync2_q, filt_q, prev_q;
    logic [2:0] cnt_q;

    // Bus idles high, so the whole input path presets to 1 to avoid a false START at reset exit.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        prev_q  <= 1'b1;
        cnt_q   <= 3'd0;
      end else begin
        sync1_q <= pin_s[i];
        sync2_q <= sync1_q;
        prev_q  <= filt_q;
        if (sync2_q == filt_q) begin
          cnt_q <= 3'd0;
        end else if (cnt_q == FLT_LAST) begin
          filt_q <= sync2_q;
          cnt_q  <= 3'd0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end

    assign filt_s[i] = filt_q;
    assign prev_s[i] = prev_q;
  end

  logic scl_f_s, sda_f_s, scl_rise_s, scl_fall_s, start_s, stop_s, accept_s, match_s;
  assign scl_f_s    = filt_s[0];
  assign sda_f_s    = filt_s[1];
  assign scl_rise_s = scl_f_s & ~prev_s[0];
  assign scl_fall_s = ~scl_f_s & prev_s[0];
  assign start_s    = scl_f_s & prev_s[1] & ~sda_f_s;
  assign stop_s     = scl_f_s & ~prev_s[1] & sda_f_s;
  assign accept_s   = byte_valid & out_ready;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic       co_q, co_d, dc_q, dc_d, bdc_q, bdc_d, valid_q, valid_d;
  logic       sda_oen_q, sda_oen_d, scl_oen_q, scl_oen_d, busy_q, busy_d;
  logic       hold_q, hold_d, ovf_q, ovf_d;

  assign match_s = (shift_q[7:1] == SLAVE_ADDR) && !shift_q[0];

  // Protocol FSM, byte shifter and output-register next state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    co_d      = co_q;
    dc_d      = dc_q;
    sda_oen_d = sda_oen_q;
    scl_oen_d = scl_oen_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    data_d    = data_q;
    bdc_d     = bdc_q;
    ovf_d     = 1'b0;
    if (accept_s) valid_d = 1'b0;
    if (scl_oen_q && !hold_q) scl_oen_d = 1'b0;
`ifdef OLED_I2C_SLAVE_STRETCH_EN
    if (hold_q && accept_s) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      bdc_d   = dc_q;
      hold_d  = 1'b0;
    end
`endif
    case (state_q)
      ST_ADDR, ST_CTRL, ST_DATA: begin
        if (scl_rise_s && (bit_cnt_q != 4'd8)) begin
          shift_d   = {shift_q[6:0], sda_f_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if ((bit_cnt_q == 4'd7) && (state_q == ST_CTRL)) begin
            co_d = shift_d[7];
            dc_d = shift_d[6];
          end
          if ((bit_cnt_q == 4'd7) && (state_q == ST_DATA)) begin
            if (!valid_q || accept_s) begin
              valid_d = 1'b1;
              data_d  = shift_d;
              bdc_d   = dc_q;
            end else begin
`ifdef OLED_I2C_SLAVE_STRETCH_EN
              hold_d = 1'b1;
`else
              ovf_d  = 1'b1;
`endif
            end
          end
        end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
          bit_cnt_d = 4'd0;
          sda_oen_d = 1'b1;
          case (state_q)
            ST_ADDR: begin
              if (match_s) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d   = ST_IGNORE;
                sda_oen_d = 1'b0;
              end
            end
            ST_CTRL: state_d = ST_CTRL_ACK;
            default: begin
              state_d   = ST_DATA_ACK;
              scl_oen_d = hold_q & ~accept_s;
            end
          endcase
        end
      end
      ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
        if (scl_fall_s) begin
          sda_oen_d = 1'b0;
          bit_cnt_d = 4'd0;
          if (state_q == ST_DATA_ACK) begin
            state_d = co_q ? ST_CTRL : ST_DATA;
          end else begin
            state_d = (state_q == ST_ADDR_ACK) ? ST_CTRL : ST_DATA;
          end
        end
      end
      ST_IDLE, ST_IGNORE: begin
        bit_cnt_d = 4'd0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Bus conditions win over whatever the state logic decided this cycle.
    if (start_s || stop_s) begin
      state_d   = start_s ? ST_ADDR : ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b0;
      scl_oen_d = 1'b0;
      busy_d    = 1'b0;
      hold_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      co_q      <= 1'b0;
      dc_q      <= 1'b0;
      sda_oen_q <= 1'b0;
      scl_oen_q <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      bdc_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      co_q      <= co_d;
      dc_q      <= dc_d;
      sda_oen_q <= sda_oen_d;
      scl_oen_q <= scl_oen_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      bdc_q     <= bdc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sda_out    = 1'b0;
  assign scl_out    = 1'b0;
  assign sda_oen    = sda_oen_q;
  assign scl_oen    = scl_oen_q;
  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_dc    = bdc_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_oled_i2c_slave.sv
// Directed bench for oled_i2c_slave: a bit-banged I2C master drives the bus and the
// received byte stream is logged and compared against hand-computed values.
module tb_oled_i2c_slave;

  logic clk = 1'b0, reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1, out_ready = 1'b0;
  logic sda_out, sda_oen, scl_out, scl_oen, byte_valid, byte_dc, overflow, busy;
  logic [7:0] byte_data;
  logic scl_bus, sda_bus;

  assign scl_bus = scl_oen ? scl_out : scl_m;
  assign sda_bus = sda_oen ? sda_out : sda_m;

  oled_i2c_slave dut (
    .clk(clk), .reset(reset), .scl_in(scl_bus), .sda_in(sda_bus),
    .sda_out(sda_out), .sda_oen(sda_oen), .scl_out(scl_out), .scl_oen(scl_oen),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .out_ready(out_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, ovf_cnt = 0;
  bit oen_seen = 1'b0;
  logic [7:0] q_data[$];
  logic       q_dc[$];

  always @(negedge clk) begin
    if (reset) begin
      if (byte_valid && out_ready) begin
        q_data.push_back(byte_data);
        q_dc.push_back(byte_dc);
      end
      if (overflow) ovf_cnt++;
      if (sda_oen) oen_seen = 1'b1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_bus !== 1'b1 && n < 4000) begin
      tick(1);
      n++;
    end
    if (scl_bus !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL scl_release: got scl=%b want 1 after %0d cycles", scl_bus, n);
    end
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(5);
    scl_m = 1'b1; tick(1); wait_scl_high(); tick(10);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(1); wait_scl_high(); tick(5);
    ack = ~sda_bus; tick(5);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; tick(10);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(1); wait_scl_high(); tick(10);
    sda_m = 1'b0; tick(10);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(5);
    scl_m = 1'b1; tick(1); wait_scl_high(); tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(5);
    n_cmp++; if (sda_oen !== 1'b0) begin n_err++; $display("FAIL rst_sda_oen: got %b want 0", sda_oen); end
    n_cmp++; if (scl_oen !== 1'b0) begin n_err++; $display("FAIL rst_scl_oen: got %b want 0", scl_oen); end
    n_cmp++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", byte_valid); end
    n_cmp++; if (byte_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", byte_data); end
    n_cmp++; if (byte_dc !== 1'b0) begin n_err++; $display("FAIL rst_dc: got %b want 0", byte_dc); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({sda_out, scl_out} !== 2'b00) begin n_err++; $display("FAIL rst_pd: got %b want 00", {sda_out, scl_out}); end
    reset = 1'b1; tick(10);
    n_cmp++; if ({busy, byte_valid, sda_oen} !== 3'b000) begin n_err++; $display("FAIL post_rst: got %b want 000", {busy, byte_valid, sda_oen}); end
  endtask

  task automatic test_single_write();
    logic a;
    out_ready = 1'b1; q_data.delete(); q_dc.delete();
    bus_start();
    send_byte(8'h78, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL sw_addr_ack: got %b want 1", a); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sw_busy: got %b want 1", busy); end
    send_byte(8'h00, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL sw_ctrl_ack: got %b want 1", a); end
    send_byte(8'hAE, a);
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL sw_data_ack: got %b want 1", a); end
    bus_stop(); tick(5);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sw_busy_stop: got %b want 0", busy); end
    n_cmp++; if (q_data.size() !== 1) begin n_err++; $display("FAIL sw_count: got %0d want 1", q_data.size()); end
    if (q_data.size() > 0) begin
      n_cmp++; if ({q_dc[0], q_data[0]} !== {1'b0, 8'hAE}) begin n_err++; $display("FAIL sw_byte: got dc=%b %h want dc=0 ae", q_dc[0], q_data[0]); end
    end
  endtask

  task automatic test_nack();
    logic a;
    logic [7:0] b[3] = '{8'h7A, 8'h40, 8'h55};
    q_data.delete(); q_dc.delete(); oen_seen = 1'b0;
    bus_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(b[i], a);
      n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL nack_%0d: got ack=%b want 0", i, a); end
    end
    bus_stop(); tick(5);
    n_cmp++; if (oen_seen !== 1'b0) begin n_err++; $display("FAIL nack_oen: got %b want 0", oen_seen); end
    n_cmp++; if (q_data.size() !== 0) begin n_err++; $display("FAIL nack_count: got %0d want 0", q_data.size()); end
  endtask

  task automatic test_stream();
    logic a;
    logic [7:0] b[5] = '{8'h78, 8'h40, 8'h11, 8'h22, 8'h33};
    logic [7:0] exp[3] = '{8'h11, 8'h22, 8'h33};
    q_data.delete(); q_dc.delete();
    bus_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(b[i], a);
      n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL st_ack_%0d: got %b want 1", i, a); end
    end
    bus_stop(); tick(5);
    n_cmp++; if (q_data.size() !== 3) begin n_err++; $display("FAIL st_count: got %0d want 3", q_data.size()); end
    for (int i = 0; i < 3; i++) begin
      if (q_data.size() > i) begin
        n_cmp++; if ({q_dc[i], q_data[i]} !== {1'b1, exp[i]}) begin n_err++; $display("FAIL st_byte_%0d: got dc=%b %h want dc=1 %h", i, q_dc[i], q_data[i], exp[i]); end
      end
    end
  endtask

  task automatic test_co_reparse();
    logic a;
    logic [7:0] b[5] = '{8'h78, 8'h80, 8'hA1, 8'hC0, 8'h7F};
    q_data.delete(); q_dc.delete();
    bus_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(b[i], a);
      n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL co_ack_%0d: got %b want 1", i, a); end
    end
    bus_stop(); tick(5);
    n_cmp++; if (q_data.size() !== 2) begin n_err++; $display("FAIL co_count: got %0d want 2", q_data.size()); end
    if (q_data.size() > 1) begin
      n_cmp++; if ({q_dc[0], q_data[0]} !== {1'b0, 8'hA1}) begin n_err++; $display("FAIL co_byte0: got dc=%b %h want dc=0 a1", q_dc[0], q_data[0]); end
      n_cmp++; if ({q_dc[1], q_data[1]} !== {1'b1, 8'h7F}) begin n_err++; $display("FAIL co_byte1: got dc=%b %h want dc=1 7f", q_dc[1], q_data[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic a, a4;
`ifdef OLED_I2C_SLAVE_STRETCH_EN
    int exp_n = 2, exp_ovf = 0;
`else
    int exp_n = 1, exp_ovf = 0 + 1;
`endif
    out_ready = 1'b0; ovf_cnt = 0; q_data.delete(); q_dc.delete();
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h00, a);
    send_byte(8'h12, a);
`ifdef OLED_I2C_SLAVE_STRETCH_EN
    fork
      send_byte(8'h34, a4);
      begin
        int n = 0;
        while (scl_oen !== 1'b1 && n < 2000) begin tick(1); n++; end
        n_cmp++; if (scl_oen !== 1'b1) begin n_err++; $display("FAIL bp_stretch: got %b want 1", scl_oen); end
        tick(40);
        n_cmp++; if (scl_oen !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b want 1", scl_oen); end
        n_cmp++; if (byte_data !== 8'h12) begin n_err++; $display("FAIL bp_keep: got %h want 12", byte_data); end
        out_ready = 1'b1;
      end
    join
    n_cmp++; if (scl_oen !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", scl_oen); end
`else
    send_byte(8'h34, a4);
    n_cmp++; if (byte_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", byte_valid); end
    n_cmp++; if (byte_data !== 8'h12) begin n_err++; $display("FAIL bp_keep: got %h want 12", byte_data); end
    n_cmp++; if (scl_oen !== 1'b0) begin n_err++; $display("FAIL bp_scl_oen: got %b want 0", scl_oen); end
`endif
    n_cmp++; if (a4 !== 1'b1) begin n_err++; $display("FAIL bp_ack: got %b want 1", a4); end
    bus_stop();
    out_ready = 1'b1; tick(10);
    n_cmp++; if (ovf_cnt !== exp_ovf) begin n_err++; $display("FAIL bp_ovf: got %0d want %0d", ovf_cnt, exp_ovf); end
    n_cmp++; if (q_data.size() !== exp_n) begin n_err++; $display("FAIL bp_count: got %0d want %0d", q_data.size(), exp_n); end
    if (q_data.size() > 0) begin
      n_cmp++; if (q_data[0] !== 8'h12) begin n_err++; $display("FAIL bp_first: got %h want 12", q_data[0]); end
    end
    if (exp_n == 2 && q_data.size() > 1) begin
      n_cmp++; if (q_data[1] !== 8'h34) begin n_err++; $display("FAIL bp_second: got %h want 34", q_data[1]); end
    end
  endtask

  task automatic test_rstart_read();
    logic a;
    out_ready = 1'b1; q_data.delete(); q_dc.delete();
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h40, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_rstart();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rs_busy: got %b want 0", busy); end
    send_byte(8'h79, a);
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rs_read_nack: got %b want 0", a); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rs_busy_read: got %b want 0", busy); end
    bus_stop(); tick(5);
    n_cmp++; if (q_data.size() !== 0) begin n_err++; $display("FAIL rs_partial: got %0d bytes want 0", q_data.size()); end
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h40, a);
    send_byte(8'h5A, a);
    bus_stop(); tick(5);
    n_cmp++; if (q_data.size() !== 1) begin n_err++; $display("FAIL rs_count: got %0d want 1", q_data.size()); end
    if (q_data.size() > 0) begin
      n_cmp++; if ({q_dc[0], q_data[0]} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL rs_byte: got dc=%b %h want dc=1 5a", q_dc[0], q_data[0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b = 8'h78;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(8);
    n_cmp++; if ({busy, sda_oen} !== 2'b11) begin n_err++; $display("FAIL ar_ack_on: got %b want 11", {busy, sda_oen}); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({busy, sda_oen, scl_oen} !== 3'b000) begin n_err++; $display("FAIL ar_release: got %b want 000", {busy, sda_oen, scl_oen}); end
    scl_m = 1'b1; sda_m = 1'b1; tick(3);
    reset = 1'b1; tick(10);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_nack();
    test_stream();
    test_co_reparse();
    test_backpressure();
    test_rstart_read();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oled_i2c_slave.md
# oled_i2c_slave

I2C target (responder) that models the OLED controller's I2C front end. It oversamples SCL/SDA on the system clock, answers writes to its 7-bit address, and decodes the SSD1306-style control byte. It delivers each received command or data byte on a valid/ready stream. It pairs with the OLED I2C master on the same bus, either for loopback verification or as the front end of an on-chip display model.

## Interface
- `SLAVE_ADDR`, default 7'h3C: 7-bit address this target ACKs.
- `FILTER_LEN`, default 2: number of consecutive equal synchronized samples required before an SCL/SDA level change is accepted. Range 1-7.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `scl_in` in 1: bus SCL level.
- `sda_in` in 1: bus SDA level.
- `sda_out` out 1: constant 0 (open-drain pull-down value).
- `sda_oen` out 1: 1 = drive SDA low (ACK), 0 = release.
- `scl_out` out 1: constant 0.
- `scl_oen` out 1: 1 = hold SCL low (stretch), 0 = release.
- `byte_valid` out 1: received byte available.
- `byte_data` out 8: received byte.
- `byte_dc` out 1: 0 = command byte, 1 = display-data byte (D/C# bit of the governing control byte).
- `out_ready` in 1: consumer accepts the byte when `byte_valid & out_ready`.
- `overflow` out 1: one-cycle pulse when a byte is dropped.
- `busy` out 1: high from the address-match ACK until STOP or repeated START.

## Operation
- Input path: each of `scl_in`/`sda_in` goes through a 2-flop synchronizer, then a FILTER_LEN glitch filter, giving `scl_f`/`sda_f`. Edges are detected on the filtered signals.
- Bus conditions:
  - START: `sda_f` falls while `scl_f` is high.
  - STOP: `sda_f` rises while `scl_f` is high.
  - These conditions override every state.
  - START (including a repeated START) enters ADDR with the bit count cleared.
  - STOP enters IDLE.
- Bit handling:
  - Data bits are sampled MSB first on each `scl_f` rising edge.
  - SDA drive changes only on `scl_f` falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If [7:1] == SLAVE_ADDR and R/W = 0: go to ADDR_ACK.
    - Otherwise (address mismatch, or any read): go to IGNORE; no ACK, so the read is NACKed.
  - ADDR_ACK: drive ACK, then go to CTRL.
  - CTRL: shift the control byte. Latch Co = bit7 and DC = bit6; the other bits are ignored. Then go to CTRL_ACK.
  - CTRL_ACK: drive ACK, then go to DATA.
  - DATA: shift 8 bits. Present the byte with `byte_dc` = latched DC. Then go to DATA_ACK.
  - DATA_ACK: drive ACK. Then go to CTRL if Co = 1, or stay in DATA if Co = 0 (streaming until STOP).
  - IGNORE: outputs released; wait for START or STOP.
- ACK drive: `sda_oen` rises on the `scl_f` falling edge after bit 8 and falls on the `scl_f` falling edge after the 9th (ACK) clock.
- Output register:
  - A byte is loaded into `byte_data`/`byte_dc` and `byte_valid` is set on the cycle after bit 8's rising edge is detected.
  - `byte_valid` holds until it is accepted.
  - Address and control bytes are never emitted.

## Timing
- Reset values:
  - `sda_oen`=0, `scl_oen`=0, `byte_valid`=0, `byte_data`=8'h00, `byte_dc`=0, `overflow`=0, `busy`=0.
  - State = IDLE, and the filters are preset to 1.
- Input latency: 2 + FILTER_LEN clk cycles from pin change to filtered edge.
- `byte_valid` asserts 1 clk after the filtered bit-8 rising edge.
- A byte is accepted in the same cycle as `byte_valid & out_ready`. `byte_valid` deasserts the next cycle unless a new byte loads in that same cycle.
- Simultaneous accept and new byte completion: the new byte loads and `byte_valid` stays high. No overflow.
- STOP or START arriving mid-byte discards the partial byte. A pending `byte_valid` is kept.
- Reset asserted mid-transfer releases SDA/SCL immediately (asynchronously) and clears all state.
- Requirement on SCL timing: SCL high and low times must each be ≥ FILTER_LEN + 4 clk.

## Configuration
- `OLED_I2C_SLAVE_STRETCH_EN`
  - Defined: when a data byte completes while `byte_valid` is still pending, the new byte waits in the shift register. `scl_oen`=1 from the next `scl_f` falling edge until the pending byte is accepted. The new byte then loads, and SCL is released 1 clk later; the ACK follows normally. `overflow` never pulses.
  - Undefined: `scl_oen` is tied to 0. In the same pending case the new byte is dropped, the old byte is kept, `overflow` pulses for 1 clk, and the ACK is still given.

## Test plan
- Write 3C, control 0x00, data 0xAE, STOP, with `out_ready`=1 -> ACK on all three bytes; one `byte_valid` with data 0xAE, `byte_dc`=0; `busy` falls after STOP.
- Address 3D, then 0x40 0x55 -> NACK on the address byte; no `byte_valid`; `sda_oen` stays 0 throughout.
- Write 3C, 0x40, then 0x11 0x22 0x33 streamed -> three bytes 0x11/0x22/0x33 with `byte_dc`=1, emitted in order.
- Write 3C, then 0x80 0xA1 0xC0 0x7F -> byte 0xA1 with dc=0, then 0x7F with dc=1 (Co=1 re-parses the control byte).
- `out_ready`=0 while two data bytes arrive -> stretch build: SCL held low until `out_ready` rises, no loss. Non-stretch build: one `overflow` pulse, and the first byte is retained.
- Repeated START mid data byte, then 3C with R/W=1 -> partial byte discarded, the read is NACKed, `busy`=0.
